// File: rtl/alu_issue_ctrl_if.sv
// Command handshake and alu operand/result bus for the issue/writeback stage.
interface alu_issue_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs;
    logic [2:0]  cmd_rt;
    logic [15:0] cmd_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_ins;
    logic [15:0] alu_out;
    logic [15:0] alu_hi;
    logic [2:0]  alu_flags;

    // Issue stage side: takes commands, drives the alu, reads its results.
    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm,
        output cmd_ready,
        output alu_a, alu_b, alu_ins,
        input  alu_out, alu_hi, alu_flags
    );

    // Command source plus alu side.
    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, cmd_imm,
        input  cmd_ready,
        input  alu_a, alu_b, alu_ins,
        output alu_out, alu_hi, alu_flags
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage in front of a combinational alu.
// Four-cycle sequence per command: IDLE (accept) -> READ -> EXEC -> WB.
module alu_issue_ctrl #(
    parameter int          NREG    = 8,
    parameter logic [15:0] HI_MASK = 16'h0060,
    parameter logic [3:0]  OP_LDI  = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_ctrl_if.slave   bus,
    output logic              done,
    output logic [15:0]       hi_q,
    output logic [2:0]        flags_q,
    input  logic [2:0]        dbg_addr,
    output logic [15:0]       dbg_data
);

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t                     state, state_nx;
    logic [NREG-1:0][15:0]      regs;
    logic [3:0]                 op_q;
    logic [2:0]                 rd_q, rs_q, rt_q;
    logic [15:0]                imm_q;
    logic                       accept;

    assign accept   = (state == IDLE) && bus.cmd_valid;
    assign dbg_data = regs[dbg_addr];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state, ready and retire pulse.
    always_comb begin
        state_nx      = state;
        bus.cmd_ready = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) state_nx = READ;
            end
            READ:    state_nx = EXEC;
            EXEC:    state_nx = WB;
            WB: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Command latch, operand fetch and writeback. Operands are copied out in
    // READ, so a destination that aliases a source is overwritten safely in WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            imm_q       <= '0;
            bus.alu_a   <= '0;
            bus.alu_b   <= '0;
            bus.alu_ins <= '0;
            regs        <= '0;
            hi_q        <= '0;
            flags_q     <= '0;
        end else begin
            if (accept) begin
                op_q  <= bus.cmd_op;
                rd_q  <= bus.cmd_rd;
                rs_q  <= bus.cmd_rs;
                rt_q  <= bus.cmd_rt;
                imm_q <= bus.cmd_imm;
            end
            if (state == READ) begin
                bus.alu_a   <= regs[rs_q];
                bus.alu_b   <= regs[rt_q];
                bus.alu_ins <= op_q;
            end
            if (state == WB) begin
                if (op_q == OP_LDI) begin
                    regs[rd_q] <= imm_q;
                end else if (op_q != 4'h0) begin
                    regs[rd_q] <= bus.alu_out;
                    flags_q    <= bus.alu_flags;
                    if (HI_MASK[op_q]) hi_q <= bus.alu_hi;
                end
            end
        end
    end

endmodule
